// File: rtl/rcpu_core.sv
// rcpu_core: 16-bit multi-cycle CPU (fetch/exec/mem/wb) over a 1-cycle-latency read-only RAM bus
module rcpu_core #(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic [15:0] memAddr,
  input  logic [15:0] memRead
);
  typedef enum logic [2:0] {FETCH, EXEC, MEM, WB, HALT} state_t;
  state_t state, state_nxt;
  logic [15:0] pc, ld_addr, a, b, res, pc_inc, pc_nxt;
  logic [15:0] gpr [4];
  logic [16:0] sum, diff;
  logic [3:0] op;
  logic [1:0] rd, rs, ld_rd;
  logic [7:0] imm;
  logic z, c, res_c, wr, flag_wr, take;
  assign op = memRead[15:12];
  assign rd = memRead[11:10];
  assign rs = memRead[9:8];
  assign imm = memRead[7:0];
  assign a = gpr[rd];
  assign b = gpr[rs];
  assign sum = {1'b0, a} + {1'b0, b};
  assign diff = {1'b0, a} - {1'b0, b};
  assign pc_inc = pc + 16'd1;
  assign take = op == 4'hC || (op == 4'hD && z) || (op == 4'hE && c);
  assign pc_nxt = take ? pc_inc + {{8{imm[7]}}, imm} : op == 4'hF ? pc : pc_inc;
  assign wr = op >= 4'h1 && op <= 4'hA;
  assign flag_wr = op >= 4'h4 && op <= 4'hA;
  assign memAddr = state == MEM ? ld_addr : pc;
  always_comb begin
    res = a;
    res_c = 1'b0;
    case (op)
      4'h1: res = {8'h00, imm};
      4'h2: res = {imm, a[7:0]};
      4'h3: res = b;
      4'h4: {res_c, res} = sum;
      4'h5: {res_c, res} = diff;
      4'h6: res = a & b;
      4'h7: res = a | b;
      4'h8: res = a ^ b;
      4'h9: res = a << imm[3:0];
      4'hA: res = a >> imm[3:0];
      default: res = a;
    endcase
  end
  always_comb begin
    state_nxt = state == FETCH ? EXEC :
                state == EXEC  ? (op == 4'hB ? MEM : op == 4'hF ? HALT : FETCH) :
                state == MEM   ? WB :
                state == WB    ? FETCH : HALT;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= FETCH;
      pc <= RESET_PC;
      ld_addr <= 16'h0000;
      ld_rd <= 2'd0;
      z <= 1'b0;
      c <= 1'b0;
      gpr <= '{default: 16'h0000};
    end else begin
      state <= state_nxt;
      if (state == EXEC) begin
        pc <= pc_nxt;
        ld_addr <= b + {8'h00, imm};
        ld_rd <= rd;
        if (wr) gpr[rd] <= res;
        if (flag_wr) begin
          z <= res == 16'h0000;
          c <= res_c;
        end
      end
      if (state == WB) gpr[ld_rd] <= memRead;
    end
  end
endmodule

// File: tb/tb_rcpu_core.sv
// tb_rcpu_core: directed spec scenarios plus random programs checked against an ISA-level model
module tb_rcpu_core;
  logic clk = 1'b0, rst = 1'b1;
  logic [15:0] memAddr, memRead;
  logic [15:0] mem [65536];
  logic [15:0] prog [$];
  logic [15:0] mr [4];
  logic [15:0] mpc;
  logic mz, mc;
  int checks = 0, errors = 0;
  rcpu_core dut (.clk(clk), .rst(rst), .memAddr(memAddr), .memRead(memRead));
  always #5 clk = ~clk;
  always @(posedge clk) memRead <= mem[memAddr];
  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic do_reset();
    rst = 1'b1;
    cycles(1);
    rst = 1'b0;
    mr = '{default: 16'h0000};
    mpc = 16'h0000;
    mz = 1'b0;
    mc = 1'b0;
  endtask
  task automatic load_prog();
    foreach (mem[i]) mem[i] = 16'h0000;
    foreach (prog[i]) mem[i] = prog[i];
  endtask
  task automatic check_state(input string t);
    chk({t, " pc"}, dut.pc, mpc);
    for (int i = 0; i < 4; i++) chk($sformatf("%s r%0d", t, i), dut.gpr[i], mr[i]);
    chk({t, " z"}, 16'(dut.z), 16'(mz));
    chk({t, " c"}, 16'(dut.c), 16'(mc));
    chk({t, " memAddr"}, memAddr, mpc);
  endtask
  // Executes the instruction at mpc architecturally; lat returns its cycle count
  task automatic model_step(output int lat);
    int op, rd, rs, imm, a, b, r, off;
    bit cy, jmp;
    op = int'(mem[mpc][15:12]);
    rd = int'(mem[mpc][11:10]);
    rs = int'(mem[mpc][9:8]);
    imm = int'(mem[mpc][7:0]);
    a = int'(mr[rd]);
    b = int'(mr[rs]);
    off = imm >= 128 ? imm - 256 : imm;
    r = a;
    cy = 1'b0;
    lat = op == 11 ? 4 : 2;
    case (op)
      1: r = imm;
      2: r = imm * 256 + a % 256;
      3: r = b;
      4: begin r = a + b; cy = r > 65535; end
      5: begin r = a - b; cy = a < b; end
      6: r = a & b;
      7: r = a | b;
      8: r = a ^ b;
      9: r = a * (1 << (imm % 16));
      10: r = a / (1 << (imm % 16));
      11: mr[rd] = mem[16'(b + imm)];
      default: r = a;
    endcase
    if (op >= 1 && op <= 10) mr[rd] = 16'(r);
    if (op >= 4 && op <= 10) begin
      mz = 16'(r) == 16'h0000;
      mc = cy;
    end
    jmp = op == 12 || (op == 13 && mz) || (op == 14 && mc);
    if (op != 15) mpc = jmp ? 16'(int'(mpc) + 1 + off) : 16'(int'(mpc) + 1);
  endtask
  initial begin
    int lat, bad;
    // reset
    prog = '{16'h0000};
    load_prog();
    cycles(2);
    do_reset();
    check_state("reset");
    // ALU
    prog = '{16'h1005, 16'h1403, 16'h4100};
    load_prog();
    do_reset();
    cycles(6);
    chk("alu r0", dut.gpr[0], 16'h0008);
    chk("alu r1", dut.gpr[1], 16'h0003);
    chk("alu z", 16'(dut.z), 16'h0000);
    chk("alu c", 16'(dut.c), 16'h0000);
    chk("alu pc", dut.pc, 16'h0003);
    // carry/zero
    prog = '{16'h1CFF, 16'h2CFF, 16'h1401, 16'h4D00};
    load_prog();
    do_reset();
    cycles(8);
    chk("carry r3", dut.gpr[3], 16'h0000);
    chk("carry z", 16'(dut.z), 16'h0001);
    chk("carry c", 16'(dut.c), 16'h0001);
    // SUB / JZ / HLT
    prog = '{16'h1807, 16'h5A00, 16'hD001, 16'h1801, 16'hF000};
    load_prog();
    do_reset();
    cycles(8);
    bad = 0;
    for (int i = 0; i < 12; i++) begin
      if (memAddr !== 16'h0004) bad++;
      cycles(1);
    end
    chk("halt memAddr bad cycles", 16'(bad), 16'h0000);
    chk("halt pc", dut.pc, 16'h0004);
    chk("branch r2", dut.gpr[2], 16'h0000);
    chk("branch z", 16'(dut.z), 16'h0001);
    // load
    prog = '{16'h1420, 16'hB100};
    load_prog();
    mem[16'h0020] = 16'hBEEF;
    do_reset();
    cycles(4);
    chk("ld mem addr", memAddr, 16'h0020);
    cycles(2);
    chk("ld r0", dut.gpr[0], 16'hBEEF);
    chk("ld pc", dut.pc, 16'h0002);
    chk("ld fetch addr", memAddr, 16'h0002);
    // reset during MEM of LD
    do_reset();
    cycles(4);
    chk("abort mem addr", memAddr, 16'h0020);
    rst = 1'b1;
    cycles(1);
    rst = 1'b0;
    chk("abort r0", dut.gpr[0], 16'h0000);
    chk("abort pc", dut.pc, 16'h0000);
    chk("abort memAddr", memAddr, 16'h0000);
    cycles(2);
    chk("abort restart r1", dut.gpr[1], 16'h0020);
    // random programs, then a halt planted at wherever each run ends up
    for (int round = 0; round < 4; round++) begin
      foreach (mem[i]) mem[i] = {4'($urandom_range(0, 14)), 12'($urandom)};
      do_reset();
      for (int n = 0; n < 150; n++) begin
        model_step(lat);
        cycles(lat);
        check_state($sformatf("rnd%0d.%0d", round, n));
      end
      mem[mpc] = 16'hF000;
      model_step(lat);
      cycles(lat + 6);
      check_state($sformatf("rnd%0d halt", round));
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
